// File: rtl/bram_asym_sched.sv
// Scheduler for an asymmetric simple-dual-port block RAM.
// Two writers share the 16-bit write port A through round-robin burst
// arbitration; the 32-bit read port B is sequenced as a FIFO over the RAM.
// A level counter provides full/empty status for both sides.
module bram_asym_sched #(
    parameter int BURST_LEN = 16,
    parameter int AW_A      = 10,
    parameter int AW_B      = AW_A - 1
) (
    input  logic            clk,
    input  logic            rst,       // active-low, asynchronous
    input  logic            req0,
    input  logic            req1,
    input  logic            vld0,
    input  logic            vld1,
    input  logic [15:0]     din0,
    input  logic [15:0]     din1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            ack0,
    output logic            ack1,
    input  logic            rd_req,
    output logic            rd_vld,
    output logic [31:0]     rd_data,
    output logic [AW_A:0]   level,
    output logic            full,
    output logic            empty,
    output logic            wea,
    output logic [AW_A-1:0] addra,
    output logic [15:0]     dina,
    output logic [AW_B-1:0] addrb,
    input  logic [31:0]     doutb
);

    localparam int LW = AW_A + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [LW-1:0] DEPTH     = {1'b1, {AW_A{1'b0}}};
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST0 = 2'd1,
        BURST1 = 2'd2
    } arb_state_t;

    arb_state_t      state_reg, state_next;
    logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic            last_served_reg, last_served_next;

    logic            wea_reg;
    logic [AW_A-1:0] addra_reg;
    logic [15:0]     dina_reg;
    logic [AW_A-1:0] wr_ptr_reg;

    logic [AW_B-1:0] addrb_reg;
    logic [AW_B-1:0] rd_ptr_reg;
    logic            rd_pend_reg;
    logic            rd_vld_reg;

    logic [LW-1:0]   level_reg, level_next;
    logic [LW-1:0]   avail;

    logic [1:0]      req_vec, vld_vec, gnt_vec, ack_vec;
    logic            wr_ack;
    logic [15:0]     wr_data;
    logic            rd_acc;

    assign req_vec = {req1, req0};
    assign vld_vec = {vld1, vld0};
    assign gnt_vec = {state_reg == BURST1, state_reg == BURST0};

    // A beat is accepted only from the granted writer while there is room.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = gnt_vec[gi] & vld_vec[gi] & ~full;
        end
    endgenerate

    assign wr_ack  = |ack_vec;
    assign wr_data = ack_vec[1] ? din1 : din0;

    // A word whose write is still registered (not yet in the RAM) must not be
    // read, so it is excluded from the readable count.
    assign avail  = level_reg - LW'(wea_reg);
    assign full   = (level_reg == DEPTH);
    assign empty  = (avail < LW'(2));
    assign rd_acc = rd_req & ~empty;

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign ack0    = ack_vec[0];
    assign ack1    = ack_vec[1];
    assign wea     = wea_reg;
    assign addra   = addra_reg;
    assign dina    = dina_reg;
    assign addrb   = addrb_reg;
    assign rd_vld  = rd_vld_reg;
    assign rd_data = doutb;
    assign level   = level_reg;

    // Arbiter next-state: round-robin on ties, burst ends on last beat or req drop.
    always_comb begin
        state_next       = state_reg;
        beat_cnt_next    = beat_cnt_reg;
        last_served_next = last_served_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = last_served_reg ? BURST0 : BURST1;
                end else if (req0) begin
                    state_next = BURST0;
                end else if (req1) begin
                    state_next = BURST1;
                end
            end
            BURST0: begin
                if (!req0 || (ack_vec[0] && beat_cnt_reg == BEAT_LAST)) begin
                    state_next       = IDLE;
                    beat_cnt_next    = '0;
                    last_served_next = 1'b0;
                end else if (ack_vec[0]) begin
                    beat_cnt_next = beat_cnt_reg + BW'(1);
                end
            end
            BURST1: begin
                if (!req1 || (ack_vec[1] && beat_cnt_reg == BEAT_LAST)) begin
                    state_next       = IDLE;
                    beat_cnt_next    = '0;
                    last_served_next = 1'b1;
                end else if (ack_vec[1]) begin
                    beat_cnt_next = beat_cnt_reg + BW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    // Level moves on commit: +1 per accepted beat, -2 per accepted read.
    always_comb begin
        level_next = level_reg;
        case ({wr_ack, rd_acc})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(2);
            2'b11:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Arbiter state, beat counter and round-robin memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            beat_cnt_reg    <= '0;
            last_served_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            beat_cnt_reg    <= beat_cnt_next;
            last_served_reg <= last_served_next;
        end
    end

    // Write port: register each accepted beat toward the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wea_reg    <= 1'b0;
            addra_reg  <= '0;
            dina_reg   <= '0;
            wr_ptr_reg <= '0;
        end else begin
            wea_reg <= wr_ack;
            if (wr_ack) begin
                addra_reg  <= wr_ptr_reg;
                dina_reg   <= wr_data;
                wr_ptr_reg <= wr_ptr_reg + AW_A'(1);
            end
        end
    end

    // Read port: issue address on accept, flag valid once the RAM has sampled it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrb_reg   <= '0;
            rd_ptr_reg  <= '0;
            rd_pend_reg <= 1'b0;
            rd_vld_reg  <= 1'b0;
        end else begin
            rd_pend_reg <= rd_acc;
            rd_vld_reg  <= rd_pend_reg;
            if (rd_acc) begin
                addrb_reg  <= rd_ptr_reg;
                rd_ptr_reg <= rd_ptr_reg + AW_B'(1);
            end
        end
    end

    // Fill level register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

endmodule

// File: tb/tb_bram_asym_sched.sv
// Bench for bram_asym_sched: a behavioural RAM, a word-queue FIFO model and
// directed scenarios with random data, followed by a random traffic phase.
module tb_bram_asym_sched;

    logic        clk;
    logic        rst;
    logic        req0, req1, vld0, vld1;
    logic [15:0] din0, din1;
    logic        gnt0, gnt1, ack0, ack1;
    logic        rd_req, rd_vld;
    logic [31:0] rd_data;
    logic [10:0] level;
    logic        full, empty;
    logic        wea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic [8:0]  addrb;
    logic [31:0] doutb;

    bram_asym_sched #(.BURST_LEN(16), .AW_A(10), .AW_B(9)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .vld0(vld0), .vld1(vld1),
        .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rd_req(rd_req), .rd_vld(rd_vld), .rd_data(rd_data),
        .level(level), .full(full), .empty(empty),
        .wea(wea), .addra(addra), .dina(dina),
        .addrb(addrb), .doutb(doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 1-cycle write, registered 32-bit read, low half = even word.
    logic [15:0] ram [0:1023];
    always @(posedge clk) begin
        if (wea) ram[addra] <= dina;
        doutb <= {ram[{addrb, 1'b1}], ram[{addrb, 1'b0}]};
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    int          mlevel;
    int          inflight;
    bit          pend_w;
    logic [9:0]  pend_addr;
    logic [15:0] pend_data;
    logic [9:0]  mwr_ptr;
    bit          pv1, pv2;
    logic [31:0] pd1, pd2;
    int          glog[$];

    // Snapshots taken at the sampling point of the last cycle
    logic        s_gnt0, s_gnt1, s_ack0, s_ack1, s_full, s_empty, s_rd_vld;
    logic [10:0] s_level;
    logic [31:0] s_rd_data;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mlevel   = 0;
        inflight = 0;
        pend_w   = 1'b0;
        mwr_ptr  = '0;
        pv1      = 1'b0;
        pv2      = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, check against the model,
    // advance the model, then return just after the rising edge.
    task automatic cycle();
        bit          exp_full, exp_empty, a0, a1, acc;
        logic [31:0] pd;
        @(negedge clk);
        s_gnt0 = gnt0; s_gnt1 = gnt1; s_ack0 = ack0; s_ack1 = ack1;
        s_level = level; s_full = full; s_empty = empty;
        s_rd_vld = rd_vld; s_rd_data = rd_data;

        chk(wea, pend_w, "wea");
        if (pend_w) begin
            chk(addra, pend_addr, "addra");
            chk(dina, pend_data, "dina");
        end
        exp_full  = (mlevel == 1024);
        exp_empty = ((mlevel - inflight) < 2);
        chk(level, mlevel, "level");
        chk(full, exp_full, "full");
        chk(empty, exp_empty, "empty");
        chk(rd_vld, pv2, "rd_vld");
        if (pv2) chk(rd_data, pd2, "rd_data");
        chk(gnt0 & gnt1, 0, "gnt_onehot");
        a0 = gnt0 & vld0 & !exp_full;
        a1 = gnt1 & vld1 & !exp_full;
        chk(ack0, a0, "ack0");
        chk(ack1, a1, "ack1");
        glog.push_back(gnt0 ? 1 : (gnt1 ? 2 : 0));

        acc = rd_req & !exp_empty;
        pd  = '0;
        if (acc && mq.size() >= 2) begin
            pd = {mq[1], mq[0]};
            void'(mq.pop_front());
            void'(mq.pop_front());
        end
        pend_w = a0 | a1;
        if (pend_w) begin
            pend_addr = mwr_ptr;
            pend_data = a1 ? din1 : din0;
            mq.push_back(pend_data);
            mwr_ptr = mwr_ptr + 10'd1;
        end
        pv2 = pv1; pd2 = pd1;
        pv1 = acc; pd1 = pd;
        mlevel   = mlevel + int'(pend_w) - 2 * int'(acc);
        inflight = int'(pend_w);

        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        int n;
        rst = 1'b0;
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0; din0 = '0; din1 = '0; rd_req = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(gnt0, 0, "rst_gnt0");   chk(gnt1, 0, "rst_gnt1");
        chk(wea, 0, "rst_wea");     chk(addra, 0, "rst_addra");
        chk(dina, 0, "rst_dina");   chk(addrb, 0, "rst_addrb");
        chk(rd_vld, 0, "rst_rd_vld"); chk(level, 0, "rst_level");
        chk(full, 0, "rst_full");   chk(empty, 1, "rst_empty");
        @(posedge clk); #1;
        rst = 1'b1;

        // Writer 0 alone, four beats 1..4
        req0 = 1;
        cycle(); chk(s_gnt0, 0, "t1_gnt_before");
        cycle(); chk(s_gnt0, 1, "t1_gnt_after");
        for (int i = 1; i <= 4; i++) begin
            vld0 = 1; din0 = 16'(i);
            cycle();
        end
        vld0 = 0; req0 = 0;
        cycle();
        cycle(); chk(s_gnt0, 0, "t1_gnt_drop"); chk(s_level, 4, "t1_level");

        // Two reads of the packed words
        rd_req = 1;
        cycle(); cycle();
        rd_req = 0;
        cycle(); chk(s_rd_vld, 1, "t3_vld_a"); chk(s_rd_data, 32'h0002_0001, "t3_data_a");
        cycle(); chk(s_rd_vld, 1, "t3_vld_b"); chk(s_rd_data, 32'h0004_0003, "t3_data_b");
        chk(s_level, 0, "t3_level"); chk(s_empty, 1, "t3_empty");
        cycle();

        // Writer 1 alone, two beats, so writer 1 is the last served
        req1 = 1;
        cycle(); cycle(); chk(s_gnt1, 1, "w1_gnt");
        vld1 = 1;
        repeat (2) begin din1 = 16'($urandom); cycle(); end
        vld1 = 0; req1 = 0;
        cycle(); cycle();

        // Both writers held: bursts of 16 alternate 0,1,0 with one idle cycle
        glog.delete();
        req0 = 1; req1 = 1; vld0 = 1; vld1 = 1;
        for (int i = 0; i < 51; i++) begin
            din0 = 16'($urandom); din1 = 16'($urandom);
            cycle();
        end
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0;
        for (int i = 0; i < 51; i++) begin
            int exp_owner;
            exp_owner = (i % 17 == 0) ? 0 : (((i / 17) % 2 == 0) ? 1 : 2);
            chk(glog[i], exp_owner, $sformatf("rr_owner_%0d", i));
        end
        cycle();

        // Drain down to level 6
        rd_req = 1; n = 0;
        while (mlevel > 6 && n < 100) begin cycle(); n++; end
        rd_req = 0;
        cycle(); cycle();
        chk(s_level, 6, "t5_level6");

        // Simultaneous write ack and read accept at level 6
        req0 = 1;
        cycle(); cycle(); chk(s_gnt0, 1, "t5_gnt");
        vld0 = 1; rd_req = 1; din0 = 16'($urandom);
        cycle(); chk(s_ack0, 1, "t5_ack");
        vld0 = 0; rd_req = 0; req0 = 0;
        cycle(); chk(s_level, 5, "t5_level5");

        // Read down to level 1, then a read request that must be ignored
        rd_req = 1;
        repeat (3) cycle();
        chk(s_level, 1, "t5_level1"); chk(s_empty, 1, "t5_empty1");
        rd_req = 0;
        cycle();
        cycle(); chk(s_rd_vld, 0, "t5_ignored_rd");

        // Fill to 1024
        req0 = 1; vld0 = 1; n = 0;
        while (mlevel < 1024 && n < 3000) begin din0 = 16'($urandom); cycle(); n++; end
        cycle(); chk(s_full, 1, "fill_full"); chk(s_level, 1024, "fill_level");
        n = 0;
        while (!s_gnt0 && n < 5) begin cycle(); n++; end
        chk(s_gnt0, 1, "fill_gnt_hold"); chk(s_ack0, 0, "fill_ack_low");

        // One read frees two slots; exactly two more beats are accepted
        rd_req = 1;
        cycle();
        rd_req = 0;
        din0 = 16'($urandom);
        cycle(); chk(s_level, 1022, "fill_after_read");
        acks = int'(s_ack0);
        repeat (6) begin din0 = 16'($urandom); cycle(); acks += int'(s_ack0); end
        chk(acks, 2, "fill_two_acks"); chk(s_level, 1024, "fill_refull");

        // Asynchronous reset mid-burst with a read in flight
        rd_req = 1;
        cycle();
        rd_req = 0;
        chk(addrb != 9'd0, 1, "pre_rst_addrb");
        rst = 1'b0;
        #1;
        chk(gnt0, 0, "arst_gnt0");   chk(gnt1, 0, "arst_gnt1");
        chk(wea, 0, "arst_wea");     chk(addra, 0, "arst_addra");
        chk(dina, 0, "arst_dina");   chk(addrb, 0, "arst_addrb");
        chk(rd_vld, 0, "arst_rd_vld"); chk(level, 0, "arst_level");
        chk(full, 0, "arst_full");   chk(empty, 1, "arst_empty");
        model_reset();
        req0 = 0; vld0 = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) cycle();

        // Writer 1 alone after reset
        req1 = 1;
        cycle(); chk(s_gnt1, 0, "post_gnt_before");
        cycle(); chk(s_gnt1, 1, "post_gnt_after");
        vld1 = 1;
        repeat (4) begin din1 = 16'($urandom); cycle(); end
        vld1 = 0; req1 = 0;
        cycle(); cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            vld0 = $urandom_range(0, 1);
            vld1 = $urandom_range(0, 1);
            din0 = 16'($urandom); din1 = 16'($urandom);
            rd_req = ($urandom_range(0, 2) == 0);
            cycle();
        end
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0; rd_req = 0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_asym_sched.md
Name: bram_asym_sched

Overview:
- Scheduler/controller for the asymmetric simple-dual-port block RAM: port A is 16-bit x 1024 (write), port B is 32-bit x 512 (read).
- Shares write port A between two requesters using round-robin burst arbitration.
- Sequences reads on port B as a FIFO over the RAM, with a level counter and full/empty flags.
- Sits between producer/consumer logic and the RAM IP; drives wea/addra/dina/addrb and receives doutb.

Parameters:
- BURST_LEN, 16: max 16-bit beats per write grant (power of 2, 2..256).
- AW_A, 10: port-A address width (port-A depth = 2^AW_A words).
- AW_B, 9: port-B address width; fixed at AW_A-1.

Ports:
- clk  in  1  single clock for controller and both RAM ports.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1  writer burst requests.
- vld0, vld1  in  1  writer beat valid.
- din0, din1  in  16  writer data.
- gnt0, gnt1  out  1  registered one-hot grant.
- ack0, ack1  out  1  beat accepted (combinational) = gnt_x & vld_x & !full.
- rd_req  in  1  consumer read request (one 32-bit word).
- rd_vld  out  1  rd_data valid.
- rd_data  out  32  = doutb, passed through unregistered.
- level  out  11  stored 16-bit words, 0..1024.
- full  out  1  level==1024.
- empty  out  1  level<2 (no complete 32-bit word).
- wea  out  1  RAM write enable.
- addra  out  AW_A  RAM write address.
- dina  out  16  RAM write data.
- addrb  out  AW_B  RAM read address.
- doutb  in  32  RAM read data; low half = even port-A address.

Behaviour:
- Reset (rst=0, async): gnt0/1=0, wea=0, addra=0, dina=0, addrb=0, rd_vld=0, level=0, wr_ptr=0, rd_ptr=0, last_served=1 (writer 0 wins the first tie), arbiter in IDLE. RAM contents are not cleared. Any pending read in flight is discarded.
- Arbiter FSM states: IDLE, BURST0, BURST1.
  - IDLE: if both requests are high, grant the writer != last_served; if one is high, grant that writer. The grant is registered: gnt_x rises the cycle after req is sampled.
  - BURST_x: on each ack_x, beat_cnt increments.
  - Exit to IDLE when ack_x occurs with beat_cnt==BURST_LEN-1, or when req_x is sampled low. On exit, last_served<=x and beat_cnt<=0.
  - IDLE always lasts at least one cycle between bursts, so there are no back-to-back grants.
  - full during a burst: ack stays low and the burst holds; beat_cnt is unchanged.
- Write path, on ack_x:
  - Next edge: wea<=1, addra<=wr_ptr, dina<=din_x, wr_ptr<=wr_ptr+1 (wraps 1023->0).
  - Otherwise wea<=0 and addra/dina hold.
  - RAM write latency is 1 cycle after wea/addra/dina are registered.
- Read path:
  - Accept when rd_req & !empty at edge k: addrb<=rd_ptr, rd_ptr+1 (wraps 511->0).
  - RAM registers addrb at edge k+1. rd_vld is high for exactly one cycle after edge k+1, and rd_data is valid then.
  - Back-to-back reads are allowed: one accept per cycle, pipelined.
  - rd_req while empty is ignored, with no rd_vld.
- Level accounting:
  - Level counts on ack (commit), not on the RAM write.
  - Write-ack only: level+1. Read-accept only: level-2. Both in the same cycle: level-1.
- Read-after-write hazard guard: empty evaluates level-minus-in-flight-writes, so the two newest words are readable only once both registered writes have reached the RAM. Effective: a word acked at edge n is readable at edge n+2 or later.
- Widths: level is 11-bit unsigned with no overflow; it cannot exceed 1024 and cannot go below 0.

Test Plan:
- Reset, then req0 alone with 4 vld beats 0x0001..0x0004 → gnt0 one cycle after req; wea pulses at addra 0..3; level=4; gnt0 drops when req0 falls.
- req0 and req1 both held, BURST_LEN=16 → grants alternate 0,1,0 with one IDLE cycle between; each burst is exactly 16 acks; addra is continuous.
- Write 0x0001..0x0004, then 2 reads → rd_data 0x0002_0001, then 0x0004_0003; each rd_vld occurs 2 cycles after its accept; level=0; empty=1.
- Fill to 1024 → full=1 and ack0 low with vld0 high; one read → level 1022; the next two beats ack; wr_ptr wraps to addra 0.
- Write and read accepted in the same cycle at level 6 → level 5. rd_req at level 1 → ignored, no rd_vld.
- Assert rst low mid-burst with a read in flight → all outputs at reset values immediately; no rd_vld afterward; after release, req1 alone is granted normally.
